// File: rtl/humansized_muldiv_seq.sv
// Sequencer for the shift/add multiplier-divider datapath: runs one RV32M-style op
// two cycles per bit. Optional HUMANSIZED_MULDIV_EARLYOUT_EN short-circuits rs2==0.
module humansized_muldiv_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic [2:0]     funct3,
    input  logic [W-1:0]   rs1,
    input  logic [W-1:0]   rs2,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   result,
    output logic [4:0]     op,
    output logic [W-1:0]   Di,
    output logic           ci,
    input  logic [2*W-1:0] PM
);

    localparam int CW = $clog2(W + 1);

    localparam logic [4:0] OP_LOAD = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SRL  = 5'b00010;
    localparam logic [4:0] OP_SLL  = 5'b00110;
    localparam logic [4:0] OP_SUB  = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BODY,
        S_FIX,
        S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    funct3_reg, funct3_next;
    logic [W-1:0]  abs_a_reg, abs_a_next;
    logic [W-1:0]  abs_b_reg, abs_b_next;
    logic          neg_a_reg, neg_a_next;
    logic          neg_b_reg, neg_b_next;
    logic          zero_b_reg, zero_b_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          phase_reg, phase_next;
    logic [W-1:0]  result_reg, result_next;

    logic          acc_neg_a, acc_neg_b;
    logic          forced;
    logic [2*W-1:0] pm_src, prod;
    logic [W-1:0]  quot, rem, fix_result;

    // Sign handling at accept: only the signed operand positions honour the MSB.
    always_comb begin
        acc_neg_a = 1'b0;
        acc_neg_b = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                acc_neg_a = rs1[W-1];
                acc_neg_b = rs2[W-1];
            end
            3'b010: acc_neg_a = rs1[W-1];
            default: ;
        endcase
    end

`ifdef HUMANSIZED_MULDIV_EARLYOUT_EN
    // A zero divisor/multiplier skipped the datapath, so FIX must not read PM.
    assign forced = zero_b_reg;
`else
    assign forced = 1'b0;
`endif

    // Forced values are substituted as fake {P,M} so the normal sign fix applies.
    always_comb begin
        pm_src = PM;
        if (forced)
            pm_src = funct3_reg[2] ? {abs_a_reg, {W{1'b1}}} : '0;
        prod = (neg_a_reg ^ neg_b_reg) ? -pm_src : pm_src;
        quot = ((neg_a_reg ^ neg_b_reg) && !zero_b_reg) ? -pm_src[W-1:0] : pm_src[W-1:0];
        rem  = neg_a_reg ? -pm_src[2*W-1:W] : pm_src[2*W-1:W];
        case (funct3_reg)
            3'b000:                 fix_result = prod[W-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod[2*W-1:W];
            3'b100, 3'b101:         fix_result = quot;
            default:                fix_result = rem;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        funct3_next = funct3_reg;
        abs_a_next  = abs_a_reg;
        abs_b_next  = abs_b_reg;
        neg_a_next  = neg_a_reg;
        neg_b_next  = neg_b_reg;
        zero_b_next = zero_b_reg;
        cnt_next    = cnt_reg;
        phase_next  = phase_reg;
        result_next = result_reg;
        op          = OP_LOAD;
        Di          = '0;
        ci          = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    funct3_next = funct3;
                    neg_a_next  = acc_neg_a;
                    neg_b_next  = acc_neg_b;
                    abs_a_next  = acc_neg_a ? -rs1 : rs1;
                    abs_b_next  = acc_neg_b ? -rs2 : rs2;
                    zero_b_next = (rs2 == '0);
                    state_next  = S_LOAD;
`ifdef HUMANSIZED_MULDIV_EARLYOUT_EN
                    if (rs2 == '0)
                        state_next = S_FIX;
`endif
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                Di         = abs_a_reg;
                cnt_next   = '0;
                phase_next = 1'b0;
                state_next = S_BODY;
            end
            S_BODY: begin
                busy = 1'b1;
                if (!funct3_reg[2]) begin
                    if (!phase_reg) begin
                        op = OP_ADD;
                        Di = abs_b_reg;
                    end else begin
                        op = OP_SRL;
                    end
                end else begin
                    if (!phase_reg) begin
                        op = OP_SLL;
                    end else begin
                        op = OP_SUB;
                        Di = ~abs_b_reg;
                        ci = 1'b1;
                    end
                end
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(W - 1))
                        state_next = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                result_next = fix_result;
                state_next  = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= S_IDLE;
            funct3_reg <= '0;
            abs_a_reg  <= '0;
            abs_b_reg  <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            zero_b_reg <= 1'b0;
            cnt_reg    <= '0;
            phase_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            funct3_reg <= funct3_next;
            abs_a_reg  <= abs_a_next;
            abs_b_reg  <= abs_b_next;
            neg_a_reg  <= neg_a_next;
            neg_b_reg  <= neg_b_next;
            zero_b_reg <= zero_b_next;
            cnt_reg    <= cnt_next;
            phase_reg  <= phase_next;
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_humansized_muldiv_seq.sv
// Directed bench for humansized_muldiv_seq with a behavioural {F,P,M} shift/add datapath.
module tb_humansized_muldiv_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     funct3 = 3'b000;
    logic [W-1:0]   rs1 = '0;
    logic [W-1:0]   rs2 = '0;
    logic           busy, done, ci;
    logic [W-1:0]   result, Di;
    logic [4:0]     op;
    logic [2*W-1:0] PM;

    humansized_muldiv_seq #(.W(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result),
        .op(op), .Di(Di), .ci(ci), .PM(PM)
    );

    always #5 clk = ~clk;

    // Datapath model: F is the extra top bit that catches carries and shifted-out bits.
    logic          dp_f;
    logic [W-1:0]  dp_p, dp_m;
    logic [W+1:0]  sub_sum;
    assign PM = {dp_p, dp_m};
    assign sub_sum = {1'b0, dp_f, dp_p} + {2'b01, Di} + (W+2)'(ci);

    always @(posedge clk) begin
        if (!rstn) begin
            dp_f <= 1'b0; dp_p <= '0; dp_m <= '0;
        end else begin
            case (op)
                5'b00001: begin dp_f <= 1'b0; dp_p <= '0; dp_m <= Di; end
                5'b00000: if (dp_m[0]) {dp_f, dp_p} <= {1'b0, dp_p} + {1'b0, Di};
                5'b00010: {dp_f, dp_p, dp_m} <= {1'b0, dp_f, dp_p, dp_m[W-1:1]};
                5'b00110: {dp_f, dp_p, dp_m} <= {dp_p, dp_m, 1'b0};
                5'b10000: if (sub_sum[W+1]) begin
                    {dp_f, dp_p} <= sub_sum[W:0];
                    dp_m[0] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    int total = 0;
    int bad = 0;
    logic [4:0]   op_trace [0:15];
    logic [W-1:0] di_trace [0:15];
    logic         busy1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int lat;
        int exp_lat;
        logic seen;
        @(negedge clk);
        funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat < 16) begin
                op_trace[lat] = op;
                di_trace[lat] = Di;
            end
            if (lat == 1) busy1 = busy;
            if (done) seen = 1'b1;
        end
        exp_lat = 2 * W + 3;
`ifdef HUMANSIZED_MULDIV_EARLYOUT_EN
        if (b == '0) exp_lat = 2;
`endif
        check_value({tag, "_done"}, 32'(seen), 32'd1);
        check_value({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_value({tag, "_res"}, 32'(result), 32'(exp));
        check_value({tag, "_busy_done"}, 32'(busy), 32'd0);
        $display("op %s f=%0d rs1=%h rs2=%h result=%h lat=%0d", tag, f, a, b, result, lat);
    endtask

    initial begin
        int n;
        int pulses;
        logic seen;

        repeat (2) @(posedge clk);
        #1;
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_result", 32'(result), 32'd0);
        check_value("rst_op", 32'(op), 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        run_op("mul_3x5", 3'b000, 4'h3, 4'h5, 4'hF);
        check_value("mul_busy_accept", 32'(busy1), 32'd1);
        check_value("mul_load_op", 32'(op_trace[1]), 32'h01);
        check_value("mul_load_di", 32'(di_trace[1]), 32'h3);
        check_value("mul_add_di", 32'(di_trace[2]), 32'h5);
        for (int k = 2; k <= 9; k++)
            check_value($sformatf("mul_body_op%0d", k), 32'(op_trace[k]),
                        (k % 2 == 0) ? 32'h00 : 32'h02);
        check_value("mul_fix_op", 32'(op_trace[10]), 32'h01);

        run_op("mulh_d_5",   3'b001, 4'hD, 4'h5, 4'hF);
        run_op("mulhu_f_f",  3'b011, 4'hF, 4'hF, 4'hE);
        run_op("mulhsu_f_f", 3'b010, 4'hF, 4'hF, 4'hF);
        run_op("mul_e_3",    3'b000, 4'hE, 4'h3, 4'hA);
        run_op("mul_5_0",    3'b000, 4'h5, 4'h0, 4'h0);
        run_op("div_9_2",    3'b100, 4'h9, 4'h2, 4'hD);
        check_value("div_sll_op", 32'(op_trace[2]), 32'h06);
        check_value("div_sub_op", 32'(op_trace[3]), 32'h10);
        check_value("div_sub_di", 32'(di_trace[3]), 32'hD);
        run_op("rem_9_2",    3'b110, 4'h9, 4'h2, 4'hF);
        run_op("divu_9_2",   3'b101, 4'h9, 4'h2, 4'h4);
        run_op("remu_9_2",   3'b111, 4'h9, 4'h2, 4'h1);
        run_op("divu_f_5",   3'b101, 4'hF, 4'h5, 4'h3);
        run_op("divu_7_0",   3'b101, 4'h7, 4'h0, 4'hF);
        run_op("remu_7_0",   3'b111, 4'h7, 4'h0, 4'h7);
        run_op("div_7_0",    3'b100, 4'h7, 4'h0, 4'hF);
        run_op("rem_9_0",    3'b110, 4'h9, 4'h0, 4'h9);
        run_op("div_8_f",    3'b100, 4'h8, 4'hF, 4'h8);
        run_op("rem_8_f",    3'b110, 4'h8, 4'hF, 4'h0);

        // start held high; rs1 changes mid-operation and must not matter
        @(negedge clk);
        funct3 = 3'b000; rs1 = 4'h2; rs2 = 4'h3; start = 1'b1;
        repeat (4) @(negedge clk);
        rs1 = 4'h7;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (done) seen = 1'b1;
        end
        check_value("hold_done", 32'(seen), 32'd1);
        check_value("hold_res", 32'(result), 32'h6);
        $display("op hold_mul_2x3 result=%h", result);
        @(negedge clk);
        check_value("hold_idle_busy", 32'(busy), 32'd0);
        check_value("hold_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        check_value("hold_reaccept", 32'(busy), 32'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_value("hold2_done", 32'(seen), 32'd1);
        check_value("hold2_res", 32'(result), 32'h5);
        $display("op hold_mul_7x3 result=%h", result);

        // reset in the middle of BODY aborts without a done pulse
        @(negedge clk);
        funct3 = 3'b000; rs1 = 4'h5; rs2 = 4'h5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_value("midrst_busy", 32'(busy), 32'd0);
        check_value("midrst_done", 32'(done), 32'd0);
        check_value("midrst_result", 32'(result), 32'd0);
        check_value("midrst_op", 32'(op), 32'd1);
        rstn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_value("midrst_no_done", 32'(pulses), 32'd0);
        $display("op midrst_abort pulses=%0d", pulses);
        run_op("mul_2x3", 3'b000, 4'h2, 4'h3, 4'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/humansized_muldiv_seq.md
Name: humansized_muldiv_seq

Overview:
- Sequencer that sits directly upstream of the human-sized shift/add multiplier-divider datapath.
- Accepts one RISC-V M-extension operation (funct3 plus two W-bit operands) and drives the datapath's op/Di/ci every cycle, two cycles per bit.
- Reads back the 2W-bit PM register, applies sign fix-up and result selection, and returns one W-bit result with a done pulse.
- Prototype of the midgetv mul/div control path.

Parameters:
- W, 4, operand width in bits; datapath built with same W; W >= 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  W  multiplicand / dividend.
- rs2  in  W  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result valid in the same cycle and held until next accept.
- result  out  W  registered result.
- op  out  5  datapath control: op[0] load; op[2:1] shift type; op[4:3] add type.
- Di  out  W  datapath operand.
- ci  out  1  datapath carry-in.
- PM  in  2W  datapath {P,M}.

Behaviour:
- Reset: clk edge with rstn=0 sets state IDLE, busy=0, done=0, result=0 and all internal registers to 0. Reset mid-operation aborts with no done.
- Datapath op codes:
  - LOAD=00001: P<=0, M<=Di.
  - ADD=00000: P+=Di if M[0].
  - SRL=00010: shift {F,P,M} right.
  - SLL=00110: shift {P,M} left.
  - SUB=10000: trial {F,P}+{1,Di}+ci; write only if no borrow, setting M[0]=1.
- Accept (IDLE, start=1):
  - Latch funct3, |rs1|, |rs2|, negA, negB, zeroB.
  - negA = rs1[W-1] for MUL, MULH, MULHSU, DIV, REM; otherwise 0.
  - negB = rs2[W-1] for MUL, MULH, DIV, REM; otherwise 0.
  - |x| is the W-bit two's-complement negation when the corresponding neg flag is set; the most negative value maps to 2^(W-1) unsigned.
  - Go to LOAD. start in any other state is ignored.
- LOAD (1 cycle): op=LOAD, Di=|rs1|, ci=0. Go to BODY with bit counter=0.
- BODY (2W cycles), phase toggles each cycle:
  - Multiply (funct3[2]=0): phase0 ADD with Di=|rs2|, ci=0; phase1 SRL.
  - Divide (funct3[2]=1): phase0 SLL; phase1 SUB with Di=~|rs2|, ci=1.
  - Counter increments after phase1. After W bits go to FIX.
- FIX (1 cycle): op=LOAD, Di=0 (harmless clear). Register result:
  - MUL: low W of product.
  - MULH/MULHSU/MULHU: high W.
  - Product = PM, negated as 2W bits if negA^negB.
  - DIV/DIVU: quotient = M, negated if (negA^negB) and !zeroB.
  - REM/REMU: remainder = P, negated if negA.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0, op=LOAD, Di=0. Return to IDLE.
- IDLE: op=LOAD, Di=0, ci=0, busy=0.
- Latency: start sampled at edge n gives done high in cycle n+2W+3 (W=4: 11 cycles). Back-to-back: next start is accepted in the cycle after done.
- Divide by zero needs no special sequence: the datapath yields quotient all-ones and remainder = dividend, and the sign fix rules above give RISC-V results.
- Signed overflow (most-negative / -1) yields quotient = most-negative, remainder = 0.

Optional Feature:
- HUMANSIZED_MULDIV_EARLYOUT_EN
- Defined: if rs2==0 at accept, skip LOAD/BODY and go straight to FIX with the result forced:
  - multiplies: 0;
  - DIV/DIVU: all-ones;
  - REM/REMU: rs1.
  - done is then high at cycle n+2.
- Undefined: zero divisors/multipliers run the full sequence with identical results.

Test Plan:
- W=4, MUL rs1=3 rs2=5 -> done exactly 11 cycles after start, result=0xF; BODY op trace alternates 00000/00010 four times.
- MULH rs1=0xD (-3) rs2=5 -> product 0xF1, result=0xF. MULHU rs1=0xF rs2=0xF -> result=0xE. MULHSU rs1=0xF rs2=0xF -> result=0xF.
- DIV rs1=0x9 (-7) rs2=2 -> result=0xD (-3). REM same operands -> 0xF (-1). DIVU 0x9/2 -> 0x4. REMU 0x9/2 -> 0x1.
- DIVU rs1=7 rs2=0 -> 0xF. REMU rs1=7 rs2=0 -> 0x7. DIV rs1=0x8 rs2=0xF -> 0x8. REM rs1=0x8 rs2=0xF -> 0x0. With EARLYOUT_EN, the divide-by-zero cases give done at n+2.
- start held high throughout, with changed rs1 mid-operation -> ignored until after done; next op is accepted the cycle after done.
- rstn=0 for one cycle mid-BODY -> next cycle busy=0, done=0, result=0, op=00001; no done pulse; a fresh MUL 2*3 then returns 0x6.
